// File: rtl/asmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : asmd_pkg
//  Description : Shared constants for the ASMD start sequencer.
//  Revision    : 1.0
// ============================================================================
package asmd_pkg;

    localparam int unsigned A_W             = 4;
    localparam int unsigned DEF_DEB_CYCLES  = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;
    localparam int unsigned ST_W            = 3;

    localparam logic [ST_W-1:0] c_ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] c_ST_ISSUE     = 3'd1;
    localparam logic [ST_W-1:0] c_ST_WAIT_CLR  = 3'd2;
    localparam logic [ST_W-1:0] c_ST_WAIT_DONE = 3'd3;
    localparam logic [ST_W-1:0] c_ST_CAPTURE   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/asmd_req_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : asmd_req_conditioner
//  Description : Synchronises, debounces and edge-detects the raw request.
//  Revision    : 1.0
// ============================================================================
module asmd_req_conditioner
    import asmd_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
)(
    input  logic clock,
    input  logic reset_b,
    input  logic req_in,
    output logic req_rise
);

    localparam int unsigned c_CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= req_in;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any return to the accepted level restarts the stability count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DEB_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign req_rise = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/asmd_start_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : asmd_start_sequencer
//  Description : Request front-end for the ASMD controller: issues Start,
//                waits for F, captures A/E and counts completed runs.
//                Optional watchdog enabled by macro SEQ_WATCHDOG_EN.
//  Revision    : 1.0
// ============================================================================
module asmd_start_sequencer
    import asmd_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned CNT_W       = 8
)(
    input  logic             clock,
    input  logic             reset_b,
    input  logic             req_in,
    input  logic             F,
    input  logic [A_W-1:0]   A,
    input  logic             E,
    output logic             Start,
    output logic             busy,
    output logic             done,
    output logic [A_W-1:0]   result_A,
    output logic             result_E,
    output logic [CNT_W-1:0] run_count,
    output logic             timeout_err
);

    logic             w_req_rise;
    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_next;
    logic             w_capture;
    logic             w_timeout;
    logic             r_start;
    logic             r_busy;
    logic             r_done;
    logic [A_W-1:0]   r_result_a;
    logic             r_result_e;
    logic [CNT_W-1:0] r_run_count;

    asmd_req_conditioner #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_cond (
        .clock    (clock),
        .reset_b  (reset_b),
        .req_in   (req_in),
        .req_rise (w_req_rise)
    );

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned c_WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_timeout_err;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == c_ST_WAIT_DONE) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
    assign timeout_err      = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req_rise) begin
                    w_next = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_next = c_ST_WAIT_CLR;
            end
            // F can still be stale from the previous run here; never look at it.
            c_ST_WAIT_CLR: begin
                w_next = c_ST_WAIT_DONE;
            end
            c_ST_WAIT_DONE: begin
                if (F) begin
                    w_next    = c_ST_CAPTURE;
                    w_capture = 1'b1;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (r_wd_cnt == c_WD_LAST) begin
                    w_next    = c_ST_IDLE;
                    w_timeout = 1'b1;
                end
`endif
            end
            c_ST_CAPTURE: begin
                w_next = c_ST_IDLE;
            end
            default: begin
                w_next = c_ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= c_ST_IDLE;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result_a  <= '0;
            r_result_e  <= 1'b0;
            r_run_count <= '0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == c_ST_ISSUE);
            r_busy  <= (w_next != c_ST_IDLE);
            r_done  <= w_capture;
            if (w_capture) begin
                r_result_a  <= A;
                r_result_e  <= E;
                r_run_count <= r_run_count + 1'b1;
            end
        end
    end

    assign Start     = r_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result_A  = r_result_a;
    assign result_E  = r_result_e;
    assign run_count = r_run_count;

endmodule
`default_nettype wire

// File: tb/tb_asmd_start_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asmd_start_sequencer
//  Description : Directed bench for asmd_start_sequencer with a behavioural
//                ASMD controller/datapath stand-in.
//  Revision    : 1.0
// ============================================================================
module tb_asmd_start_sequencer;

    logic       clock = 1'b0;
    logic       reset_b = 1'b0;
    logic       req_in = 1'b0;
    logic       F;
    logic [3:0] A;
    logic       E;
    logic       Start, busy, done, result_E, timeout_err;
    logic [3:0] result_A;
    logic [1:0] run_count;

    logic       use_model = 1'b1;
    logic       f_drv = 1'b0;
    logic [3:0] a_drv = 4'd0;
    logic       e_drv = 1'b0;

    int n_assert = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int start_wide = 0;
    int done_cnt = 0;
    logic prev_start = 1'b0;

    // Controller/datapath stand-in: Start clears A and F, count until A=1100, then F.
    logic [1:0] m_state = 2'd0;
    logic [3:0] m_A = 4'd0;
    logic       m_E = 1'b0;
    logic       m_F = 1'b1;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        case (m_state)
            2'd0: if (Start) begin m_A <= 4'd0; m_F <= 1'b0; m_state <= 2'd1; end
            2'd1: begin
                m_A <= m_A + 4'd1;
                m_E <= m_A[2];
                if (m_A[2] && m_A[3]) m_state <= 2'd2;
            end
            2'd2: begin m_F <= 1'b1; m_state <= 2'd0; end
            default: m_state <= 2'd0;
        endcase
    end

    assign F = use_model ? m_F : f_drv;
    assign A = use_model ? m_A : a_drv;
    assign E = use_model ? m_E : e_drv;

    always @(posedge clock) begin
        #2;
        if (Start === 1'b1) begin
            start_cnt++;
            if (prev_start) start_wide++;
        end
        prev_start = (Start === 1'b1);
        if (done === 1'b1) done_cnt++;
    end

    asmd_start_sequencer #(
        .DEB_CYCLES  (16),
        .TIMEOUT_CYC (64),
        .CNT_W       (2)
    ) dut (
        .clock       (clock),
        .reset_b     (reset_b),
        .req_in      (req_in),
        .F           (F),
        .A           (A),
        .E           (E),
        .Start       (Start),
        .busy        (busy),
        .done        (done),
        .result_A    (result_A),
        .result_E    (result_E),
        .run_count   (run_count),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_done(input string tag, input int prev, input int bound);
        int k;
        k = 0;
        while (done_cnt == prev && k < bound) begin
            @(negedge clock);
            k++;
        end
        check(tag, 32'(done_cnt - prev), 32'd1);
    endtask

    initial begin
        int s;
        int d;
        int lat;
        int n;

        cyc(3);
        reset_b = 1'b1;
        cyc(1);
        check("rst_start", Start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result_A", result_A, 0);
        check("rst_run_count", run_count, 0);
        check("rst_timeout", timeout_err, 0);

        // Short glitch must never reach the FSM.
        req_in = 1'b1;
        cyc(5);
        req_in = 1'b0;
        cyc(40);
        check("glitch_no_start", start_cnt, 0);

        // Clean request through the behavioural controller.
        d = done_cnt;
        lat = 0;
        req_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (Start === 1'b1 && lat == 0) lat = i;
        end
        req_in = 1'b0;
        n_assert++;
        assert (lat >= 17 && lat <= 19) else begin
            n_fail++;
            $error("FAIL start_latency: observed=%0d expected=17..19", lat);
        end
        wait_done("run1_done", d, 40);
        check("run1_result_A", result_A, 13);
        check("run1_result_E", result_E, 1);
        check("run1_run_count", run_count, 1);
        cyc(2);
        check("run1_busy_after", busy, 0);
        check("run1_start_count", start_cnt, 1);
        check("run1_start_width", start_wide, 0);
        cyc(30);

        // Second request edge while waiting for F is dropped.
        use_model = 1'b0;
        f_drv = 1'b0;
        a_drv = 4'd5;
        e_drv = 1'b0;
        s = start_cnt;
        d = done_cnt;
        req_in = 1'b1;
        cyc(22);
        check("drop_busy", busy, 1);
        req_in = 1'b0;
        cyc(20);
        req_in = 1'b1;
        cyc(21);
        check("drop_no_second_start", start_cnt - s, 1);
        check("drop_still_busy", busy, 1);
        f_drv = 1'b1;
        wait_done("drop_done", d, 10);
        check("drop_result_A", result_A, 5);
        check("drop_result_E", result_E, 0);
        check("drop_run_count", run_count, 2);
        cyc(2);
        check("drop_busy_after", busy, 0);
        req_in = 1'b0;
        cyc(30);
        check("drop_no_late_start", start_cnt - s, 1);

        // Asynchronous reset in the middle of WAIT_DONE.
        f_drv = 1'b0;
        req_in = 1'b1;
        cyc(25);
        check("mid_busy", busy, 1);
        reset_b = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result_A", result_A, 0);
        check("mid_rst_run_count", run_count, 0);
        check("mid_rst_done", done, 0);
        req_in = 1'b0;
        cyc(2);
        reset_b = 1'b1;
        s = start_cnt;
        cyc(5);
        check("mid_idle_busy", busy, 0);
        check("mid_idle_start", start_cnt - s, 0);

        // Two-bit run counter wraps after four runs.
        use_model = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            d = done_cnt;
            req_in = 1'b1;
            cyc(20);
            req_in = 1'b0;
            wait_done("wrap_done", d, 40);
            check("wrap_run_count", run_count, 32'(k % 4));
            cyc(25);
        end

        // No F: watchdog abort, or indefinite wait without it.
        use_model = 1'b0;
        f_drv = 1'b0;
        d = done_cnt;
        req_in = 1'b1;
        n = 0;
        while (Start !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("wd_start_seen", Start, 1);
`ifdef SEQ_WATCHDOG_EN
        n = 0;
        while (timeout_err !== 1'b1 && n < 120) begin
            @(negedge clock);
            n++;
        end
        check("wd_cycles_to_timeout", n, 66);
        check("wd_timeout_err", timeout_err, 1);
        cyc(2);
        check("wd_busy", busy, 0);
        check("wd_no_done", done_cnt - d, 0);
        check("wd_run_count", run_count, 0);
        check("wd_sticky", timeout_err, 1);
`else
        cyc(100);
        check("nowd_busy", busy, 1);
        check("nowd_timeout_err", timeout_err, 0);
        check("nowd_no_done", done_cnt - d, 0);
        f_drv = 1'b1;
        wait_done("nowd_done", d, 10);
        check("nowd_run_count", run_count, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
